// File: rtl/clarke_transform.sv
// Streaming Clarke transform: ADC phase currents -> Q15 alpha/beta with DC-offset calibration.
// Define CLARKE_THREE_PHASE_EN to use ic (with its own offset) and the three-phase equations.
module clarke_transform #(
    parameter int WIDTH     = 16,
    parameter int CAL_LOG2  = 4,
    parameter int INV_SQRT3 = 18919,
    parameter int INV3      = 10923
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cal_start,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] ia,
    input  logic signed [WIDTH-1:0] ib,
    input  logic signed [WIDTH-1:0] ic,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] alpha,
    output logic signed [WIDTH-1:0] beta,
    output logic                    sat,
    output logic                    cal_busy,
    output logic                    cal_done
);
    // in_valid/out_valid are qualifiers only: there is no ready, every valid sample taken
    // in RUN reappears with out_valid exactly two clocks later, bubbles included.
    localparam int AW = WIDTH + CAL_LOG2;
    localparam int PW = 2 * WIDTH + 8;
    localparam logic signed [PW-1:0] SAT_MAX = PW'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);
    localparam logic signed [PW-1:0] HALF    = PW'(1 << 14);

    // Returns {clamped_flag, value} with value limited to the signed WIDTH range.
    function automatic logic [WIDTH:0] sat_w(input logic signed [PW-1:0] v);
        if (v > SAT_MAX) return {1'b1, SAT_MAX[WIDTH-1:0]};
        if (v < SAT_MIN) return {1'b1, SAT_MIN[WIDTH-1:0]};
        return {1'b0, v[WIDTH-1:0]};
    endfunction

    typedef enum logic {RUN = 1'b0, CAL = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic [CAL_LOG2-1:0]     cnt_q, cnt_d;
    logic signed [AW-1:0]    acc_a_q, acc_a_d, acc_b_q, acc_b_d, sum_a, sum_b;
    logic signed [WIDTH-1:0] off_a_q, off_a_d, off_b_q, off_b_d;
    logic                    cal_done_q, cal_done_d;

    logic                    s1_valid_q, s1_valid_d, s1_sat_q, s1_sat_d;
    logic signed [WIDTH-1:0] ia_c_q, ia_c_d, ib_c_q, ib_c_d;
    logic                    sat_ia, sat_ib, sat_ic;

    logic                    out_valid_q, sat_q, sat_d, sat_al, sat_be;
    logic signed [WIDTH-1:0] alpha_q, alpha_d, beta_q, beta_d;
    logic signed [PW-1:0]    alpha_w, beta_w;

`ifdef CLARKE_THREE_PHASE_EN
    logic signed [AW-1:0]    acc_c_q, acc_c_d, sum_c;
    logic signed [WIDTH-1:0] off_c_q, off_c_d, ic_c_q, ic_c_d;
`else
    logic                    ic_unused;
    logic [WIDTH-1:0]        inv3_unused;
    assign ic_unused   = ^ic;
    assign inv3_unused = WIDTH'(INV3);
`endif

    // Calibration FSM and offset update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_a_d    = acc_a_q;
        acc_b_d    = acc_b_q;
        off_a_d    = off_a_q;
        off_b_d    = off_b_q;
        cal_done_d = 1'b0;
        sum_a      = acc_a_q + {{CAL_LOG2{ia[WIDTH-1]}}, ia};
        sum_b      = acc_b_q + {{CAL_LOG2{ib[WIDTH-1]}}, ib};
`ifdef CLARKE_THREE_PHASE_EN
        acc_c_d    = acc_c_q;
        off_c_d    = off_c_q;
        sum_c      = acc_c_q + {{CAL_LOG2{ic[WIDTH-1]}}, ic};
`endif
        case (state_q)
            RUN: begin
                if (cal_start) begin
                    state_d = CAL;
                    cnt_d   = '0;
                    acc_a_d = '0;
                    acc_b_d = '0;
`ifdef CLARKE_THREE_PHASE_EN
                    acc_c_d = '0;
`endif
                end
            end
            CAL: begin
                if (in_valid) begin
                    acc_a_d = sum_a;
                    acc_b_d = sum_b;
`ifdef CLARKE_THREE_PHASE_EN
                    acc_c_d = sum_c;
`endif
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        // Taking the upper WIDTH bits is the arithmetic shift by CAL_LOG2.
                        off_a_d    = sum_a[AW-1:CAL_LOG2];
                        off_b_d    = sum_b[AW-1:CAL_LOG2];
`ifdef CLARKE_THREE_PHASE_EN
                        off_c_d    = sum_c[AW-1:CAL_LOG2];
`endif
                        cal_done_d = 1'b1;
                        state_d    = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Stage 1: offset removal with the offsets in force this cycle
    always_comb begin
        s1_valid_d = in_valid && (state_q == RUN);
        {sat_ia, ia_c_d} = sat_w(PW'(ia) - PW'(off_a_q));
        {sat_ib, ib_c_d} = sat_w(PW'(ib) - PW'(off_b_q));
`ifdef CLARKE_THREE_PHASE_EN
        {sat_ic, ic_c_d} = sat_w(PW'(ic) - PW'(off_c_q));
`else
        sat_ic = 1'b0;
`endif
        s1_sat_d = sat_ia | sat_ib | sat_ic;
    end

    // Stage 2: Q15 multiply with round-half-up before the clamp
    always_comb begin
`ifdef CLARKE_THREE_PHASE_EN
        alpha_w = ((PW'(ia_c_q) * 2 - PW'(ib_c_q) - PW'(ic_c_q)) * PW'(INV3) + HALF) >>> 15;
        beta_w  = ((PW'(ib_c_q) - PW'(ic_c_q)) * PW'(INV_SQRT3) + HALF) >>> 15;
`else
        alpha_w = PW'(ia_c_q);
        beta_w  = ((PW'(ia_c_q) + PW'(ib_c_q) * 2) * PW'(INV_SQRT3) + HALF) >>> 15;
`endif
        {sat_al, alpha_d} = sat_w(alpha_w);
        {sat_be, beta_d}  = sat_w(beta_w);
        sat_d = s1_sat_q | sat_al | sat_be;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            acc_a_q     <= '0;
            acc_b_q     <= '0;
            off_a_q     <= '0;
            off_b_q     <= '0;
            cal_done_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_sat_q    <= 1'b0;
            ia_c_q      <= '0;
            ib_c_q      <= '0;
            out_valid_q <= 1'b0;
            alpha_q     <= '0;
            beta_q      <= '0;
            sat_q       <= 1'b0;
`ifdef CLARKE_THREE_PHASE_EN
            acc_c_q     <= '0;
            off_c_q     <= '0;
            ic_c_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_a_q     <= acc_a_d;
            acc_b_q     <= acc_b_d;
            off_a_q     <= off_a_d;
            off_b_q     <= off_b_d;
            cal_done_q  <= cal_done_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= s1_valid_q;
`ifdef CLARKE_THREE_PHASE_EN
            acc_c_q     <= acc_c_d;
            off_c_q     <= off_c_d;
`endif
            if (s1_valid_d) begin
                ia_c_q   <= ia_c_d;
                ib_c_q   <= ib_c_d;
                s1_sat_q <= s1_sat_d;
`ifdef CLARKE_THREE_PHASE_EN
                ic_c_q   <= ic_c_d;
`endif
            end
            // Outputs hold their last sample across bubbles.
            if (s1_valid_q) begin
                alpha_q <= alpha_d;
                beta_q  <= beta_d;
                sat_q   <= sat_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign alpha     = alpha_q;
    assign beta      = beta_q;
    assign sat       = sat_q;
    assign cal_busy  = (state_q == CAL);
    assign cal_done  = cal_done_q;

endmodule

// File: tb/tb_clarke_transform.sv
// Directed bench for clarke_transform: hand-computed vectors, expected-queue scoreboard.
// Build with CLARKE_THREE_PHASE_EN defined to exercise the three-phase equations.
module tb_clarke_transform;
    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cal_start = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [15:0] ia = '0, ib = '0, ic = '0;
    logic               out_valid, sat, cal_busy, cal_done;
    logic signed [15:0] alpha, beta;

    logic [32:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    logic        drv_tag = 1'b0;
    logic        tag_now = 1'b0;
    logic        tag_d1 = 1'b0;
    logic [32:0] e;

`ifdef CLARKE_THREE_PHASE_EN
    localparam int E1_A = 667;
    localparam int E1_B = 0;
`else
    localparam int E1_A = 1000;
    localparam int E1_B = 577;
`endif

    clarke_transform dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cal_start (cal_start),
        .in_valid  (in_valid),
        .ia        (ia),
        .ib        (ib),
        .ic        (ic),
        .out_valid (out_valid),
        .alpha     (alpha),
        .beta      (beta),
        .sat       (sat),
        .cal_busy  (cal_busy),
        .cal_done  (cal_done)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Driver tasks: inputs change on the falling edge only.
    task automatic drive(input bit cal, input bit vld, input int a, input int b, input int c,
                         input bit exp_out, input int ea, input int eb, input bit es);
        @(negedge clk);
        cal_start = cal;
        in_valid  = vld;
        ia        = 16'(a);
        ib        = 16'(b);
        ic        = 16'(c);
        drv_tag   = vld && exp_out;
        if (vld && exp_out) exp_q.push_back({es, 16'(ea), 16'(eb)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        cal_start = 1'b0;
        drv_tag   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // 16 calibration samples, a second cal_start in the middle that must be ignored.
    task automatic cal_samples(input int a, input int b, input int c);
        done_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            drive(i == 8, 1, a, b, c, 0, 0, 0, 0);
            if (i == 3) check("cal_busy_mid", 32'(cal_busy), 32'd1);
        end
        idle(2);
        check("cal_busy_end", 32'(cal_busy), 32'd0);
        check("cal_done_pulses", 32'(done_cnt), 32'd1);
    endtask

    // Scoreboard: out_valid must follow the tagged input by two edges; data from exp_q.
    always @(posedge clk) begin
        tag_now = drv_tag;
        #1;
        if (!rst_n) begin
            tag_d1 = 1'b0;
        end else begin
            check("out_valid", 32'(out_valid), 32'(tag_d1));
            if (out_valid && tag_d1) begin
                if (exp_q.size() == 0) begin
                    check("exp_q_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("alpha", 32'($unsigned(alpha)), 32'(e[31:16]));
                    check("beta", 32'($unsigned(beta)), 32'(e[15:0]));
                    check("sat", 32'(sat), 32'(e[32]));
                end
            end
            if (cal_done) done_cnt++;
            tag_d1 = tag_now;
        end
    end

    initial begin
        apply_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alpha", 32'($unsigned(alpha)), 32'd0);
        check("rst_beta", 32'($unsigned(beta)), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        check("rst_cal_busy", 32'(cal_busy), 32'd0);
        check("rst_cal_done", 32'(cal_done), 32'd0);

        drive(0, 1, 1000, 0, 0, 1, E1_A, E1_B, 0);
        idle(3);

`ifdef CLARKE_THREE_PHASE_EN
        drive(0, 1, 3000, -1500, -1500, 1, 3000, 0, 0);
        drive(0, 1, 1000, 0, 0, 1, E1_A, E1_B, 0);
        idle(3);
        check("hold_alpha", 32'($unsigned(alpha)), 32'(16'(E1_A)));
`else
        // Back-to-back burst, saturation corners, then a one-cycle gap.
        drive(0, 1, 0, 16384, 0, 1, 0, 18919, 0);
        drive(0, 1, 32767, 32767, 0, 1, 32767, 32767, 1);
        drive(0, 1, -32768, -32768, 0, 1, -32768, -32768, 1);
        idle(1);
        drive(0, 1, 1000, 0, 0, 1, 1000, 577, 0);
        idle(3);
        check("hold_alpha", 32'($unsigned(alpha)), 32'(16'(1000)));
        check("hold_beta", 32'($unsigned(beta)), 32'(16'(577)));
`endif

        // cal_start with a valid sample: that sample still uses the old (zero) offsets.
        drive(1, 1, 1000, 0, 0, 1, E1_A, E1_B, 0);
        cal_samples(100, -50, -50);
        drive(0, 1, 1100, -50, -50, 1, E1_A, E1_B, 0);
        idle(3);

`ifndef CLARKE_THREE_PHASE_EN
        // off_a = -100, off_b = 0: ia - off_a overflows and clamps.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cal_samples(-100, 0, 0);
        drive(0, 1, 32767, 0, 0, 1, 32767, 18918, 1);
        idle(3);
`endif

        // Reset in the middle of calibration.
        done_cnt = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) drive(0, 1, 500, 500, 500, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        cal_start = 1'b0;
        drv_tag   = 1'b0;
        #1;
        check("midcal_rst_busy", 32'(cal_busy), 32'd0);
        check("midcal_rst_done", 32'(cal_done), 32'd0);
        check("midcal_rst_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 1000, 0, 0, 1, E1_A, E1_B, 0);
        idle(4);
        check("midcal_no_done", 32'(done_cnt), 32'd0);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
